// File: rtl/core_run_pkg.sv
// Shared constants for the core run controller: FSM encoding, default timing
// parameters and the width of the issued-pulse counter.
package core_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_STEP = 2'b11
    } run_state_e;

    localparam int unsigned DEFAULT_DIV_VALUE       = 32'd10000000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd500000;
    localparam int          CE_COUNT_W              = 16;

endpackage

// File: rtl/core_run_ctrl_step_debounce.sv
// Step push-button conditioning: 2-flop synchronizer, run-length debouncer and
// rising-edge detector producing a one-cycle step_evt per accepted press.
module step_debounce
    import core_run_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic step_evt
);

    localparam int RUN_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       vld_q;
    logic             last_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             lvl_q;
    logic             armed_q;
    logic             evt_q;
    logic             accept;

    // run_q holds how many consecutive equal samples have been seen, saturating
    // at DEBOUNCE_CYCLES; samples start once the synchronizer holds real data.
    always_comb begin
        run_d  = run_q;
        accept = 1'b0;
        if (vld_q[1]) begin
            if (sync2_q != last_q) begin
                run_d = RUN_W'(1);
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + 1'b1;
            end
            accept = (run_d == RUN_MAX);
        end
    end

    // armed_q only sets after a stable released level, so a button held
    // through reset cannot fire until it has been released and pressed again.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
            last_q  <= 1'b0;
            run_q   <= '0;
            lvl_q   <= 1'b0;
            armed_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            run_q   <= run_d;
            evt_q   <= 1'b0;
            if (vld_q[1]) begin
                last_q <= sync2_q;
            end
            if (accept) begin
                lvl_q <= sync2_q;
                evt_q <= sync2_q & ~lvl_q & armed_q;
                if (!sync2_q) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

    assign step_evt = evt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/halt controller that gates a core running on clk through a
// registered one-cycle clock enable, and counts the enables it issues.
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int unsigned DIV_VALUE       = DEFAULT_DIV_VALUE,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_sw,
    input  logic                  step_btn,
    input  logic                  halt_req,
    input  logic                  halt_clr,
    output logic                  core_ce,
    output logic [1:0]            state,
    output logic [CE_COUNT_W-1:0] ce_count
);

    localparam logic [31:0] DIV_LAST = 32'(DIV_VALUE - 32'd1);

    run_state_e            state_q;
    run_state_e            state_d;
    logic [31:0]           div_q;
    logic [31:0]           div_d;
    logic                  core_ce_q;
    logic                  core_ce_d;
    logic [CE_COUNT_W-1:0] ce_count_q;
    logic                  step_evt;

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_in  (step_btn),
        .step_evt(step_evt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_sw) begin
                    state_d = ST_RUN;
                end else if (step_evt) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!run_sw) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (halt_clr) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The divider only advances while already in RUN, so entry restarts it
        // from zero and the first enable lands DIV_VALUE cycles later.
        div_d = '0;
        if (state_q == ST_RUN) begin
            div_d = (div_q == DIV_LAST) ? 32'd0 : div_q + 32'd1;
        end

        core_ce_d = ((state_q == ST_RUN) && (div_q == DIV_LAST)) || (state_d == ST_STEP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            core_ce_q  <= 1'b0;
            ce_count_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            core_ce_q  <= core_ce_d;
            ce_count_q <= ce_count_q + CE_COUNT_W'(core_ce_d);
        end
    end

    assign core_ce  = core_ce_q;
    assign state    = state_q;
    assign ce_count = ce_count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the run/step/halt rules.
module tb_core_run_ctrl;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        halt_clr = 1'b0;
    logic        core_ce;
    logic [1:0]  state;
    logic [15:0] ce_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_state = 0;
    int m_k = 0;
    int m_count = 0;
    bit m_ce = 1'b0;
    bit m_lvl = 1'b0;
    bit m_armed = 1'b0;
    bit m_evt = 1'b0;
    bit rawq[$];
    bit hist[$];

    core_run_ctrl #(
        .DIV_VALUE(DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run_sw  (run_sw),
        .step_btn(step_btn),
        .halt_req(halt_req),
        .halt_clr(halt_clr),
        .core_ce (core_ce),
        .state   (state),
        .ce_count(ce_count)
    );

    always #5 clk = ~clk;

    // Model: state per the transition rules, enables counted from RUN entry,
    // button accepted when the last DEB synchronized samples agree.
    task automatic model_step();
        int  nxt;
        bit  ce;
        bit  s;
        bit  same;
        if (!reset) begin
            m_state = 0; m_ce = 1'b0; m_count = 0; m_k = 0;
            m_lvl = 1'b0; m_armed = 1'b0; m_evt = 1'b0;
            rawq.delete(); hist.delete();
            return;
        end
        nxt = m_state;
        ce  = 1'b0;
        case (m_state)
            0: if (run_sw) nxt = 1; else if (m_evt) nxt = 3;
            1: if (halt_req) nxt = 2; else if (!run_sw) nxt = 0;
            2: if (halt_clr) nxt = 0;
            default: nxt = 0;
        endcase
        if (m_state == 1) begin
            m_k++;
            if (m_k % DIV == 0) ce = 1'b1;
        end
        if (nxt == 1 && m_state != 1) m_k = 0;
        if (nxt == 3) ce = 1'b1;
        m_ce    = ce;
        m_count = (m_count + int'(ce)) % 65536;
        m_state = nxt;

        m_evt = 1'b0;
        rawq.push_back(step_btn);
        if (rawq.size() >= 3) begin
            s = rawq[rawq.size() - 3];
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            if (hist.size() == DEB) begin
                same = 1'b1;
                foreach (hist[i]) if (hist[i] != s) same = 1'b0;
                if (same) begin
                    if (s && !m_lvl && m_armed) m_evt = 1'b1;
                    if (!s) m_armed = 1'b1;
                    m_lvl = s;
                end
            end
        end
        if (rawq.size() > 3) void'(rawq.pop_front());
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0; halt_clr = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run_sw = 1'b1;
        repeat (3) tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (core_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", core_ce); end
        checks++; if (ce_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", ce_count); end
        run_sw = 1'b0; reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_run();
        apply_reset();
        run_sw = 1'b1;
        tick();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_entry: got %0d expected 1", state); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (core_ce !== (k % DIV == 0)) begin
                errors++; $display("FAIL run_ce k=%0d: got %b expected %b", k, core_ce, (k % DIV == 0));
            end
        end
        checks++; if (ce_count !== 16'd5) begin errors++; $display("FAIL run_count: got %0d expected 5", ce_count); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state: got %0d expected 1", state); end
        run_sw = 1'b0;
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL run_exit: got %0d expected 0", state); end
        $display("test_run done: ce_count=%0d", ce_count);
    endtask

    task automatic test_step();
        int n_step = 0;
        int n_ce = 0;
        apply_reset();
        repeat (6) tick();
        for (int i = 0; i < 24; i++) begin
            step_btn = (i == 0 || (i >= 2 && i < 12));
            tick();
            n_step += int'(state == 2'b11);
            n_ce   += int'(core_ce);
        end
        checks++; if (n_step != 1) begin errors++; $display("FAIL step_states: got %0d expected 1", n_step); end
        checks++; if (n_ce != 1) begin errors++; $display("FAIL step_ce: got %0d expected 1", n_ce); end
        checks++; if (ce_count !== 16'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", ce_count); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL step_final: got %0d expected 0", state); end
        $display("test_step done: step_cycles=%0d ce_pulses=%0d", n_step, n_ce);
    endtask

    task automatic test_held_btn();
        int n_step = 0;
        reset = 1'b0; step_btn = 1'b1; run_sw = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_step += int'(state == 2'b11);
        end
        checks++; if (n_step != 0) begin errors++; $display("FAIL held_nostep: got %0d expected 0", n_step); end
        for (int i = 0; i < 22; i++) begin
            step_btn = (i >= 8 && i < 16);
            tick();
            n_step += int'(state == 2'b11);
        end
        checks++; if (n_step != 1) begin errors++; $display("FAIL held_repress: got %0d expected 1", n_step); end
        checks++; if (ce_count !== 16'd1) begin errors++; $display("FAIL held_count: got %0d expected 1", ce_count); end
        $display("test_held_btn done: step_cycles=%0d", n_step);
    endtask

    task automatic test_halt();
        apply_reset();
        repeat (6) tick();
        run_sw = 1'b1;
        repeat (3) tick();
        halt_req = 1'b1; run_sw = 1'b0;
        tick();
        halt_req = 1'b0;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL halt_enter: got %0d expected 2", state); end
        for (int i = 0; i < 14; i++) begin
            step_btn = (i < 8);
            run_sw   = (i % 3 == 0);
            tick();
            checks++;
            if (state !== 2'b10 || core_ce !== 1'b0) begin
                errors++; $display("FAIL halt_hold i=%0d: got state=%0d ce=%b expected state=2 ce=0", i, state, core_ce);
            end
        end
        run_sw = 1'b0; halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL halt_clear: got %0d expected 0", state); end
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL halt_noqueue: got %0d expected 0", state); end
        checks++; if (ce_count !== 16'd0) begin errors++; $display("FAIL halt_count: got %0d expected 0", ce_count); end
        $display("test_halt done");
    endtask

    task automatic test_wrap();
        apply_reset();
        // Preload near the top so the wrap is reached without 65535 real pulses.
        force dut.ce_count_q = 16'hFFFE;
        #1;
        release dut.ce_count_q;
        checks++; if (ce_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h expected fffe", ce_count); end
        run_sw = 1'b1;
        tick();
        repeat (4) tick();
        checks++; if (ce_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", ce_count); end
        repeat (4) tick();
        checks++; if (ce_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", ce_count); end
        repeat (4) tick();
        checks++; if (ce_count !== 16'h0001) begin errors++; $display("FAIL wrap_one: got %h expected 0001", ce_count); end
        run_sw = 1'b0;
        tick();
        $display("test_wrap done: ce_count=%h", ce_count);
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        run_sw = 1'b1;
        tick();
        repeat (7) tick();
        checks++; if (ce_count !== 16'd1) begin errors++; $display("FAIL midrst_pre: got %0d expected 1", ce_count); end
        reset = 1'b0;
        tick();
        checks++; if (core_ce !== 1'b0) begin errors++; $display("FAIL midrst_ce: got %b expected 0", core_ce); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL midrst_state: got %0d expected 0", state); end
        checks++; if (ce_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", ce_count); end
        reset = 1'b1;
        tick();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL midrst_rerun: got %0d expected 1", state); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (core_ce !== (k == 4)) begin
                errors++; $display("FAIL midrst_div k=%0d: got %b expected %b", k, core_ce, (k == 4));
            end
        end
        run_sw = 1'b0;
        tick();
        $display("test_reset_mid_run done");
    endtask

    task automatic test_random();
        int seg_left = 0;
        bit seg_lvl = 1'b0;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
            halt_req = ($urandom_range(0, 15) == 0);
            halt_clr = ($urandom_range(0, 9) == 0);
            if (seg_left == 0) begin
                seg_lvl  = 1'($urandom_range(0, 1));
                seg_left = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(4, 14));
            end
            step_btn = seg_lvl;
            seg_left--;
            reset = ($urandom_range(0, 249) != 0);
            tick();
            checks++;
            if (state !== 2'(m_state) || core_ce !== m_ce || ce_count !== 16'(m_count)) begin
                errors++;
                $display("FAIL random c=%0d: got state=%0d ce=%b cnt=%0d expected state=%0d ce=%b cnt=%0d",
                         c, state, core_ce, ce_count, m_state, m_ce, m_count);
            end
        end
        reset = 1'b1; run_sw = 1'b0; halt_req = 1'b0; halt_clr = 1'b0; step_btn = 1'b0;
        $display("test_random done: model ce_count=%0d", m_count);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run();
        test_step();
        test_held_btn();
        test_halt();
        test_wrap();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
